// File: rtl/arm_pkg.sv
// ============================================================================
// Module      : arm_pkg
// Description : Shared ARM core constants and types (register file geometry).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;
    localparam int SB_CNT_W   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/sb_counter.sv
// ============================================================================
// Module      : sb_counter
// Description : Pending-writer counter for one register; an increment and a
//               decrement in the same cycle cancel, and decrements stop at 0.
//               Optional macro SB_ERR_CHECK_EN adds underflow/overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_zero,
    output logic o_max
`ifdef SB_ERR_CHECK_EN
    ,
    output logic o_underflow,
    output logic o_overflow
`endif
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_up;
    logic             w_dn;

    assign o_zero = (r_cnt == '0);
    assign o_max  = (r_cnt == {CNT_W{1'b1}});
    assign w_up   = i_inc & ~i_dec & ~o_max;
    assign w_dn   = i_dec & ~i_inc & ~o_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_up) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_dn) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

`ifdef SB_ERR_CHECK_EN
    assign o_underflow = i_dec & ~i_inc & o_zero;
    assign o_overflow  = i_inc & ~i_dec & o_max;

    // The hazard logic blocks issue into a saturated register.
    a_no_inc_at_max: assert property (@(posedge clk) disable iff (rst) !o_overflow);
`endif

endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Issue-side register scoreboard; stalls ID on pending writers.
//               Optional macro SB_ERR_CHECK_EN adds the sticky sb_err output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import arm_pkg::*;
#(
    parameter int NUM_REGS = arm_pkg::NUM_REGS,
    parameter int CNT_W    = arm_pkg::SB_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic                id_flush,
    input  arm_pkg::reg_addr_t  id_src1,
    input  arm_pkg::reg_addr_t  id_src2,
    input  logic                id_two_src,
    input  logic                id_wb_en,
    input  arm_pkg::reg_addr_t  id_dest,
    input  logic                wb_en,
    input  arm_pkg::reg_addr_t  wb_dest,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_vec
`ifdef SB_ERR_CHECK_EN
    ,
    output logic                sb_err
`endif
);

    logic [NUM_REGS-1:0] w_zero;
    logic [NUM_REGS-1:0] w_max;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic                w_raw1;
    logic                w_raw2;
    logic                w_full;
    logic                w_hazard;
    logic                w_go;

`ifdef SB_ERR_CHECK_EN
    logic [NUM_REGS-1:0] w_underflow;
    logic [NUM_REGS-1:0] w_overflow;
    logic                r_sb_err;
`endif

    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
            assign w_inc[r] = issue & id_wb_en & (id_dest == REG_ADDR_W'(r));
            assign w_dec[r] = wb_en & (wb_dest == REG_ADDR_W'(r));

            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .i_inc  (w_inc[r]),
                .i_dec  (w_dec[r]),
                .o_zero (w_zero[r]),
                .o_max  (w_max[r])
`ifdef SB_ERR_CHECK_EN
                ,
                .o_underflow (w_underflow[r]),
                .o_overflow  (w_overflow[r])
`endif
            );
        end
    endgenerate

    // Hazards use registered counts only: a same-cycle writeback is not bypassed.
    assign w_raw1   = ~w_zero[id_src1];
    assign w_raw2   = id_two_src & ~w_zero[id_src2];
    assign w_full   = id_wb_en & w_max[id_dest];
    assign w_hazard = w_raw1 | w_raw2 | w_full;
    assign w_go     = ~rst & id_valid & ~id_flush;

    assign stall    = w_go & w_hazard;
    assign issue    = w_go & ~w_hazard;
    assign busy_vec = ~w_zero;

`ifdef SB_ERR_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_err <= 1'b0;
        end else if ((|w_underflow) | (|w_overflow)) begin
            r_sb_err <= 1'b1;
        end
    end

    assign sb_err = r_sb_err;
`endif

endmodule

`default_nettype wire
